// File: rtl/jrb_regfile_pc_unit.sv
// jrb8 register file, conditional-jump PC and buffered output port.
// Optional return stack enabled by defining JRB_PC_STACK_EN.
module jrb_regfile_pc_unit #(
   parameter int DATA_W    = 8,
   parameter int NUM_REGS  = 4,
   parameter int PC_W      = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_W-1:0]            bus_in,
   input  logic                         reg_we,
   input  logic [$clog2(NUM_REGS)-1:0]  wsel,
   input  logic [$clog2(NUM_REGS)-1:0]  rsel_a,
   input  logic [$clog2(NUM_REGS)-1:0]  rsel_b,
   output logic [DATA_W-1:0]            rd_a,
   output logic [DATA_W-1:0]            rd_b,
   input  logic                         pc_inc,
   input  logic                         tgt_lo_we,
   input  logic                         tgt_hi_we,
   input  logic                         jmp,
   input  logic [2:0]                   cond,
   input  logic [3:0]                   flags,
   input  logic                         call,
   input  logic                         ret,
   output logic [PC_W-1:0]              pc,
   input  logic                         out_push,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(OUT_DEPTH):0]   out_count,
   output logic                         out_ovf
);
   localparam int OW = $clog2(OUT_DEPTH);
   localparam int HW = PC_W - DATA_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] tgt_lo_q, tgt_lo_d;
   logic [HW-1:0]     tgt_hi_q, tgt_hi_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_plus1, target;
   logic              cond_true;

   always_comb begin
      regs_d = regs_q;
      if (reg_we) regs_d[wsel] = bus_in;
   end

   assign rd_a = regs_q[rsel_a];
   assign rd_b = regs_q[rsel_b];

   always_comb begin
      tgt_lo_d = tgt_lo_we ? bus_in : tgt_lo_q;
      tgt_hi_d = tgt_hi_we ? bus_in[HW-1:0] : tgt_hi_q;
   end

   // flags = {O,S,C,Z}
   always_comb begin
      case (cond)
         3'd0:    cond_true = 1'b1;
         3'd1:    cond_true = flags[0];
         3'd2:    cond_true = ~flags[0];
         3'd3:    cond_true = flags[1];
         3'd4:    cond_true = ~flags[1];
         3'd5:    cond_true = flags[2];
         3'd6:    cond_true = flags[3];
         default: cond_true = 1'b0;
      endcase
   end

   assign pc_plus1 = pc_q + PC_W'(1);
   assign target   = {tgt_hi_q, tgt_lo_q};
   assign pc       = pc_q;

`ifdef JRB_PC_STACK_EN
   logic [PC_W-1:0] stk_q [4];
   logic [PC_W-1:0] stk_d [4];
   logic [1:0]      sp_q, sp_d, sp_m1;
   logic [2:0]      depth_q, depth_d;

   assign sp_m1 = sp_q - 2'd1;

   // Circular stack: a push on a full stack naturally lands on the oldest slot.
   always_comb begin
      stk_d   = stk_q;
      sp_d    = sp_q;
      depth_d = depth_q;
      pc_d    = pc_q;
      if (cond_true && (jmp || call)) begin
         pc_d = target;
         if (call) begin
            stk_d[sp_q] = pc_plus1;
            sp_d        = sp_q + 2'd1;
            depth_d     = (depth_q == 3'd4) ? depth_q : depth_q + 3'd1;
         end
      end else if (ret) begin
         if (depth_q != 3'd0) begin
            pc_d    = stk_q[sp_m1];
            sp_d    = sp_m1;
            depth_d = depth_q - 3'd1;
         end else begin
            pc_d = pc_plus1;
         end
      end else if (pc_inc) begin
         pc_d = pc_plus1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) stk_q[i] <= '0;
         sp_q    <= '0;
         depth_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) stk_q[i] <= stk_d[i];
         sp_q    <= sp_d;
         depth_q <= depth_d;
      end
   end
`else
   logic unused_ret;
   assign unused_ret = ret;

   always_comb begin
      pc_d = pc_q;
      if (cond_true && (jmp || call)) pc_d = target;
      else if (pc_inc)                pc_d = pc_plus1;
   end
`endif

   logic [DATA_W-1:0] mem_q [OUT_DEPTH];
   logic [DATA_W-1:0] mem_d [OUT_DEPTH];
   logic [OW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW:0]       cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              full, do_pop, do_push;

   assign full    = (cnt_q == (OW+1)'(OUT_DEPTH));
   assign do_pop  = (cnt_q != '0) && out_ready;
   assign do_push = out_push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q | (out_push & full & ~do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = bus_in;
         wr_ptr_d        = wr_ptr_q + OW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + OW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (OW+1)'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - (OW+1)'(1);
   end

   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = (cnt_q != '0);
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)  regs_q[i] <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) mem_q[i]  <= '0;
         tgt_lo_q <= '0;
         tgt_hi_q <= '0;
         pc_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)  regs_q[i] <= regs_d[i];
         for (int i = 0; i < OUT_DEPTH; i++) mem_q[i]  <= mem_d[i];
         tgt_lo_q <= tgt_lo_d;
         tgt_hi_q <= tgt_hi_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule

// File: tb/tb_jrb_regfile_pc_unit.sv
// Bench for jrb_regfile_pc_unit: abstract model checked every cycle plus literal pins.
module tb_jrb_regfile_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  bus_in = '0;
   logic        reg_we = 1'b0;
   logic [1:0]  wsel = '0, rsel_a = '0, rsel_b = '0;
   logic [7:0]  rd_a, rd_b;
   logic        pc_inc = 1'b0, tgt_lo_we = 1'b0, tgt_hi_we = 1'b0, jmp = 1'b0;
   logic [2:0]  cond = '0;
   logic [3:0]  flags = '0;
   logic        call = 1'b0, ret = 1'b0;
   logic [15:0] pc;
   logic        out_push = 1'b0, out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [2:0]  out_count;
   logic        out_ovf;

   int total = 0;
   int bad   = 0;

   jrb_regfile_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .reg_we(reg_we), .wsel(wsel),
      .rsel_a(rsel_a), .rsel_b(rsel_b), .rd_a(rd_a), .rd_b(rd_b), .pc_inc(pc_inc),
      .tgt_lo_we(tgt_lo_we), .tgt_hi_we(tgt_hi_we), .jmp(jmp), .cond(cond),
      .flags(flags), .call(call), .ret(ret), .pc(pc), .out_push(out_push),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   // Behavioural model
   logic [7:0]  m_regs [4];
   logic [15:0] m_tgt;
   logic [15:0] m_pc;
   logic        m_ovf;
   logic [7:0]  m_fq [$];
   logic [15:0] m_stk [$];

   function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
      bit z = f[0], cy = f[1], s = f[2], o = f[3];
      case (c)
         3'd0: return 1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return cy;
         3'd4: return !cy;
         3'd5: return s;
         3'd6: return o;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
         m_tgt = 16'h0000;
         m_pc  = 16'h0000;
         m_ovf = 1'b0;
         m_fq.delete();
         m_stk.delete();
      end else begin
         bit taken, popq, wasfull;
         taken = (jmp || call) && cond_ok(cond, flags);
`ifdef JRB_PC_STACK_EN
         if (taken) begin
            if (call) begin
               if (m_stk.size() == 4) void'(m_stk.pop_front());
               m_stk.push_back(m_pc + 16'd1);
            end
            m_pc = m_tgt;
         end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_pc = m_pc + 16'd1;
         end else if (pc_inc) m_pc = m_pc + 16'd1;
`else
         if (taken)       m_pc = m_tgt;
         else if (pc_inc) m_pc = m_pc + 16'd1;
`endif
         if (tgt_lo_we) m_tgt[7:0]  = bus_in;
         if (tgt_hi_we) m_tgt[15:8] = bus_in;
         if (reg_we) m_regs[wsel] = bus_in;
         wasfull = (m_fq.size() == 4);
         popq = out_ready && (m_fq.size() > 0);
         if (popq) void'(m_fq.pop_front());
         if (out_push) begin
            if (wasfull && !popq) m_ovf = 1'b1;
            else                  m_fq.push_back(bus_in);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("rd_a", 32'(rd_a), 32'(m_regs[rsel_a]));
      chk("rd_b", 32'(rd_b), 32'(m_regs[rsel_b]));
      chk("out_valid", 32'(out_valid), 32'(m_fq.size() > 0));
      chk("out_count", 32'(out_count), 32'(m_fq.size()));
      chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
      if (m_fq.size() > 0) chk("out_data", 32'(out_data), 32'(m_fq[0]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
   endtask

   task automatic set_tgt(input logic [7:0] hi, input logic [7:0] lo);
      bus_in = hi; tgt_hi_we = 1'b1; tick(); tgt_hi_we = 1'b0;
      bus_in = lo; tgt_lo_we = 1'b1; tick(); tgt_lo_we = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_cnt", 32'(out_count), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_ovf", 32'(out_ovf), 32'h0);

      // Register write/read
      reg_we = 1'b1; wsel = 2'd2; bus_in = 8'hA5; rsel_a = 2'd2; rsel_b = 2'd1;
      #1 chk("rd_old", 32'(rd_a), 32'h00);
      tick(); reg_we = 1'b0;
      #1 chk("rd_new", 32'(rd_a), 32'hA5);
      chk("rd_other", 32'(rd_b), 32'h00);
      reg_we = 1'b1; wsel = 2'd1; bus_in = 8'h3C; tick(); reg_we = 1'b0;
      #1 chk("rd_b_new", 32'(rd_b), 32'h3C);

      // Conditional jump
      set_tgt(8'h12, 8'h34);
      jmp = 1'b1; cond = 3'd1; flags = 4'b0000; pc_inc = 1'b1; tick();
      chk("jz_untaken", 32'(pc), 32'h0001);
      flags = 4'b0001; tick();
      chk("jz_taken", 32'(pc), 32'h1234);
      pc_inc = 1'b0; cond = 3'd0; bus_in = 8'h56; tgt_lo_we = 1'b1; tick();
      tgt_lo_we = 1'b0;
      chk("tgt_same_cycle", 32'(pc), 32'h1234);
      tick();
      chk("tgt_updated", 32'(pc), 32'h1256);
      jmp = 1'b0;
      for (int c = 1; c < 8; c++) begin
         flags = 4'b1010; cond = 3'(c); jmp = 1'b1; tick();
      end
      jmp = 1'b0;

      // PC wrap and priority
      set_tgt(8'hFF, 8'hFF);
      jmp = 1'b1; cond = 3'd0; tick(); jmp = 1'b0;
      chk("pc_ffff", 32'(pc), 32'hFFFF);
      pc_inc = 1'b1; tick();
      chk("pc_wrap", 32'(pc), 32'h0000);
      jmp = 1'b1; tick();
      chk("jmp_over_inc", 32'(pc), 32'hFFFF);
      cond = 3'd7; tick();
      chk("never_inc", 32'(pc), 32'h0000);
      jmp = 1'b0; pc_inc = 1'b0; cond = 3'd0;

      // FIFO
      do_reset();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("empty_pop", 32'(out_count), 32'h0);
      out_push = 1'b1; bus_in = 8'h01; tick();
      chk("push_valid", 32'(out_valid), 32'h1);
      for (int i = 2; i <= 4; i++) begin
         bus_in = 8'(i); tick();
      end
      chk("full_cnt", 32'(out_count), 32'h4);
      chk("full_no_ovf", 32'(out_ovf), 32'h0);
      bus_in = 8'h77; out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("pp_cnt", 32'(out_count), 32'h4);
      chk("pp_ovf", 32'(out_ovf), 32'h0);
      chk("pp_head", 32'(out_data), 32'h02);
      bus_in = 8'h05; tick(); out_push = 1'b0;
      chk("ovf_set", 32'(out_ovf), 32'h1);
      chk("ovf_cnt", 32'(out_count), 32'h4);
      out_ready = 1'b1;
      #1 chk("pop0", 32'(out_data), 32'h02);
      tick(); chk("pop1", 32'(out_data), 32'h03);
      tick(); chk("pop2", 32'(out_data), 32'h04);
      tick(); chk("pop3", 32'(out_data), 32'h77);
      tick(); chk("drained", 32'(out_valid), 32'h0);
      chk("ovf_sticky", 32'(out_ovf), 32'h1);
      tick(); out_ready = 1'b0;
      out_push = 1'b1; bus_in = 8'h9E; out_ready = 1'b1; tick();
      out_push = 1'b0; out_ready = 1'b0;
      chk("no_bypass", 32'(out_count), 32'h1);
      tick();

      // Call / return
      do_reset();
      set_tgt(8'h00, 8'h10);
      jmp = 1'b1; tick(); jmp = 1'b0;
      chk("pc_0010", 32'(pc), 32'h0010);
      set_tgt(8'h02, 8'h00);
      call = 1'b1; cond = 3'd0; tick(); call = 1'b0;
      chk("call", 32'(pc), 32'h0200);
      ret = 1'b1; tick();
`ifdef JRB_PC_STACK_EN
      chk("ret", 32'(pc), 32'h0011);
      tick();
      chk("ret_empty", 32'(pc), 32'h0012);
      ret = 1'b0;
      for (int i = 0; i < 5; i++) begin
         call = 1'b1; tick();
      end
      call = 1'b0; ret = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      ret = 1'b0;
`else
      chk("ret_ignored", 32'(pc), 32'h0200);
      ret = 1'b0; call = 1'b1; cond = 3'd7; pc_inc = 1'b1; tick();
      chk("call_untaken", 32'(pc), 32'h0201);
      call = 1'b0; pc_inc = 1'b0; cond = 3'd0;
`endif
      // Async reset mid-cycle
      pc_inc = 1'b1; tick(); tick(); pc_inc = 1'b0;
      #2 rst_n = 1'b1;
      #1 chk("async_pc", 32'(pc), 32'h0);
      chk("async_rd", 32'(rd_a), 32'h0);
      tick(); rst_n = 1'b0; tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
